// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-meter add-request path.
package parking_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_HOLDOFF = 2'd2
  } arb_state_e;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_CNT_W = 3;
  localparam int DEF_GAP   = 2;

  localparam int CH_ADD1 = 0;
  localparam int CH_ADD2 = 1;
  localparam int CH_ADD3 = 2;
  localparam int CH_ADD4 = 3;

endpackage

// File: rtl/coin_req_slot.sv
// One add channel: rising-edge detect, saturating pending counter, drop pulse.
module coin_req_slot
  import parking_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             flush_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             drop_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             req_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drop_q, drop_d;
  logic             rise;

  assign rise = req_i & ~req_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    drop_d  = 1'b0;
    if (flush_i) begin
      count_d = '0;
    end else if (rise && dec_i) begin
      count_d = count_q;
    end else if (rise) begin
      if (count_q == CNT_MAX) drop_d = 1'b1;
      else                    count_d = count_q + 1'b1;
    end else if (dec_i) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      req_q   <= req_i;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign count_o = count_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/coin_request_arbiter.sv
// Queues coin/add button presses per channel and issues spaced, round-robin
// one-cycle add grants to the parking-meter FSM.
module coin_request_arbiter
  import parking_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             flush,
  input  logic             meter_ready,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic             pending_any,
  output logic [N_REQ-1:0] drop
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = $clog2(GAP + 1);

  arb_state_e       state_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [GAP_W-1:0] gap_q;
  logic [N_REQ-1:0] grant_q;
  logic             grant_valid_q;

  logic [CNT_W-1:0] count [N_REQ];
  logic [N_REQ-1:0] nonzero;
  logic [N_REQ-1:0] dec;
  logic [N_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic             issue;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    coin_req_slot #(.CNT_W(CNT_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req[i]),
      .flush_i (flush),
      .dec_i   (dec[i]),
      .count_o (count[i]),
      .drop_o  (drop[i])
    );
    assign nonzero[i] = |count[i];
  end

  // Search starts just after the last winner so every channel gets a turn.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!pick_valid && nonzero[PTR_W'(idx)]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'(idx);
      end
    end
  end

  assign pick_onehot = N_REQ'(1) << pick_idx;
  assign issue       = (state_q == S_IDLE) && meter_ready && !flush && pick_valid;
  assign dec         = issue ? pick_onehot : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= PTR_W'(N_REQ - 1);
      gap_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            grant_q       <= pick_onehot;
            grant_valid_q <= 1'b1;
            rr_ptr_q      <= pick_idx;
            state_q       <= S_ISSUE;
          end else begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
          end
        end
        S_ISSUE: begin
          grant_q       <= '0;
          grant_valid_q <= 1'b0;
          gap_q         <= GAP_W'(GAP - 1);
          state_q       <= S_HOLDOFF;
        end
        S_HOLDOFF: begin
          if (gap_q == '0) state_q <= S_IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: begin
          grant_q       <= '0;
          grant_valid_q <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign pending_any = |nonzero;

endmodule

// File: tb/tb_coin_request_arbiter.sv
// Directed and randomized bench for coin_request_arbiter against a
// pending-count / cooldown reference model.
module tb_coin_request_arbiter;
  import parking_pkg::*;

  localparam int N   = DEF_N_REQ;
  localparam int MAX = (1 << DEF_CNT_W) - 1;
  localparam int GP  = DEF_GAP;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         flush = 1'b0;
  logic         meter_ready = 1'b0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         pending_any;
  logic [N-1:0] drop;

  int total = 0;
  int bad   = 0;

  // Reference model: queued presses per channel, last winner, cycles until next issue.
  int           m_cnt [N];
  logic [N-1:0] m_prev;
  int           m_ptr;
  int           m_cool;
  logic [N-1:0] exp_grant, exp_drop;
  logic         exp_pend;

  int n_grant [N];
  int n_drop  [N];

  coin_request_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flush       (flush),
    .meter_ready (meter_ready),
    .grant       (grant),
    .grant_valid (grant_valid),
    .pending_any (pending_any),
    .drop        (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic f, input logic mr, input logic rs);
    int pick;
    logic rise;
    exp_grant = '0;
    exp_drop  = '0;
    if (rs) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_prev   = '0;
      m_ptr    = N - 1;
      m_cool   = 0;
      exp_pend = 1'b0;
      return;
    end
    pick = -1;
    if (m_cool == 0 && mr && !f)
      for (int k = 1; k <= N; k++)
        if (pick < 0 && m_cnt[(m_ptr + k) % N] > 0) pick = (m_ptr + k) % N;
    if (pick >= 0) begin
      exp_grant[pick] = 1'b1;
      m_ptr  = pick;
      m_cool = GP + 1;
    end else if (m_cool > 0) begin
      m_cool--;
    end
    exp_pend = 1'b0;
    for (int i = 0; i < N; i++) begin
      rise = r[i] && !m_prev[i];
      if (f) m_cnt[i] = 0;
      else if (rise && pick == i) m_cnt[i] = m_cnt[i];
      else if (rise) begin
        if (m_cnt[i] == MAX) exp_drop[i] = 1'b1;
        else m_cnt[i]++;
      end else if (pick == i) m_cnt[i]--;
      if (m_cnt[i] > 0) exp_pend = 1'b1;
    end
    m_prev = r;
  endtask

  task automatic step(input logic [N-1:0] r, input logic f, input logic mr, input logic rs);
    @(negedge clk);
    req = r; flush = f; meter_ready = mr; rst = rs;
    @(posedge clk);
    model_edge(r, f, mr, rs);
    #1;
    check("grant", 32'(grant), 32'(exp_grant));
    check("grant_valid", 32'(grant_valid), 32'(|exp_grant));
    check("drop", 32'(drop), 32'(exp_drop));
    check("pending_any", 32'(pending_any), 32'(exp_pend));
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (grant[i]) n_grant[i]++;
      if (drop[i])  n_drop[i]++;
    end
  endtask

  task automatic clear_tally();
    foreach (n_grant[i]) begin
      n_grant[i] = 0;
      n_drop[i]  = 0;
    end
  endtask

  // Runs with the given inputs until a grant appears; an expired budget is a failure.
  task automatic wait_grant(input logic [N-1:0] r, input int budget, output logic [N-1:0] seen);
    seen = '0;
    for (int c = 0; c < budget && seen == '0; c++) begin
      step(r, 1'b0, 1'b1, 1'b0);
      seen = grant;
    end
    check("grant_within_budget", 32'(seen != '0), 32'd1);
  endtask

  initial begin
    logic [N-1:0] seen;
    logic [N-1:0] r;
    logic         f, mr, rs;
    int           after_flush;

    // Reset
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    check("reset_grant", 32'(grant), 32'd0);

    // Single pulse on add3: grant two edges after sampling
    clear_tally();
    step(4'b0100, 1'b0, 1'b1, 1'b0);
    check("pulse_pending", 32'(pending_any), 32'd1);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    check("pulse_grant", 32'(grant), 32'b0100);
    for (int c = 0; c < 6; c++) step('0, 1'b0, 1'b1, 1'b0);
    check("pulse_grant_count", 32'(n_grant[CH_ADD3]), 32'd1);
    check("pulse_pending_clear", 32'(pending_any), 32'd0);

    // All four rising together, from reset so add1 leads
    step('0, 1'b0, 1'b1, 1'b1);
    clear_tally();
    step(4'b1111, 1'b0, 1'b1, 1'b0);
    wait_grant(4'b0000, 4, seen);
    check("all4_first", 32'(seen), 32'b0001);
    for (int c = 0; c < 20; c++) step('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) check("all4_grants", 32'(n_grant[i]), 32'd1);
    check("all4_no_drop", 32'(n_drop[0] + n_drop[1] + n_drop[2] + n_drop[3]), 32'd0);

    // Held button counts once
    clear_tally();
    for (int c = 0; c < 20; c++) step(4'b0001, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step('0, 1'b0, 1'b1, 1'b0);
    check("held_grants", 32'(n_grant[CH_ADD1]), 32'd1);

    // Nine presses on add2 while blocked: saturate at 7, two drops, then drain
    clear_tally();
    for (int p = 0; p < 9; p++) begin
      step(4'b0010, 1'b0, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0, 1'b0);
    end
    check("sat_drops", 32'(n_drop[CH_ADD2]), 32'd2);
    check("sat_no_grant", 32'(n_grant[CH_ADD2]), 32'd0);
    for (int c = 0; c < 40; c++) step('0, 1'b0, 1'b1, 1'b0);
    check("sat_drain", 32'(n_grant[CH_ADD2]), 32'd7);

    // Flush right after a grant: pulse completes, nothing further
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b1001, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    wait_grant(4'b0000, 4, seen);
    clear_tally();
    step('0, 1'b1, 1'b1, 1'b0);
    after_flush = 0;
    for (int c = 0; c < 12; c++) step('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) after_flush += n_grant[i];
    check("flush_no_grants", 32'(after_flush), 32'd0);
    check("flush_pending", 32'(pending_any), 32'd0);

    // Reset during hold-off with add2 still queued
    for (int p = 0; p < 4; p++) begin
      step(4'b0010, 1'b0, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0, 1'b0);
    end
    wait_grant(4'b0000, 4, seen);
    step('0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1, 1'b1);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_pending", 32'(pending_any), 32'd0);
    step('0, 1'b0, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 1'b1, 1'b0);
    wait_grant(4'b0000, 4, seen);
    check("rst_first_ch0", 32'(seen), 32'b0001);

    // Randomized traffic
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
      f  = ($urandom_range(0, 31) == 0);
      mr = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 149) == 0);
      step(r, f, mr, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coin_request_arbiter.md
Name: coin_request_arbiter

Overview:
- Sits between the four coin/add push-button inputs and the parking-meter FSM add lines.
- Converts each button press into a rising-edge event and queues events per channel in saturating counters.
- Issues exactly one one-cycle add grant at a time, in round-robin order, spaced by a hold-off so the meter FSM settles between credits.
- Ensures simultaneous or rapid presses are never merged or lost silently; overflow is flagged.

Parameters:
- N_REQ, 4, number of add channels (channel 0..3 map to add1..add4)
- CNT_W, 3, width of per-channel pending counter; max queued presses = 2^CNT_W-1 = 7
- GAP, 2, hold-off cycles after a grant before the next grant may be issued (GAP >= 1)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req  input  N_REQ  synchronized button levels; bit i high = add(i+1) pressed
- flush  input  1  synchronous clear of all pending counts (driven by meter rst1/rst2)
- meter_ready  input  1  high when meter FSM may accept an add pulse
- grant  output  N_REQ  one-hot, registered, one-cycle add pulse to meter
- grant_valid  output  1  OR of grant, registered
- pending_any  output  1  high when any pending count is nonzero, registered-derived
- drop  output  N_REQ  one-cycle pulse: press on channel i lost to saturation

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values:
  - grant=0, grant_valid=0, drop=0, pending_any=0.
  - All counts=0; edge register req_d=0.
  - FSM=IDLE; rr_ptr=N_REQ-1, so channel 0 has first priority.
- Edge detect: rise[i] = req[i] & ~req_d[i]; req_d <= req every cycle. A held button counts once.
- Per-channel count update, per edge, in priority order:
  - flush: count=0, drop=0.
  - Else rise and dec both on the same channel: count unchanged.
  - Else rise only: count+1; if count already at max, hold count and pulse drop[i].
  - Else dec only: count-1.
  - dec[i] is asserted only in the edge where IDLE issues to channel i.
- FSM states: IDLE, ISSUE, HOLDOFF.
  - IDLE:
    - If meter_ready and any count>0 and not flush: pick the first nonzero channel searching rr_ptr+1 upward, wrapping mod N_REQ.
    - Then set grant=onehot(pick), grant_valid=1, dec pick, rr_ptr=pick, go ISSUE.
    - Otherwise stay in IDLE with grant=0.
  - ISSUE: grant=0, grant_valid=0, gap_cnt=GAP-1, go HOLDOFF.
  - HOLDOFF: if gap_cnt==0 go IDLE, else gap_cnt-1. Stays in HOLDOFF exactly GAP cycles.
- Latency:
  - A press sampled at edge E0 increments the count at E0.
  - The earliest grant is high during the cycle following E1 (2-cycle latency from sample to grant).
  - Back-to-back grants are GAP+2 cycles apart (start to start); default 4.
- meter_ready low in IDLE blocks issue; counts keep accumulating. Ready dropping during ISSUE/HOLDOFF does not abort the sequence.
- flush during ISSUE/HOLDOFF: counts cleared, in-flight grant pulse still completes, FSM continues normally.
- flush in IDLE suppresses issue that edge.
- pending_any = OR over (count!=0), computed from current registered counts.
- Only one grant bit is ever high; grant is never high two consecutive cycles.
- rst mid-operation: all state returns to reset values at that edge; any grant is cut.

Decomposition:
- Shared package parking_pkg:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, HOLDOFF=2'd2).
  - Default N_REQ, CNT_W, GAP constants.
  - Channel-index constants CH_ADD1..CH_ADD4.
- One sub-module: coin_req_slot. It holds the per-channel edge detect, saturating counter and drop pulse, instanced N_REQ times.
- Round-robin pick stays combinational inside coin_request_arbiter.

Test Plan:
- Reset, then a 1-cycle pulse on req[2] with meter_ready=1 -> grant=4'b0100 for one cycle 2 cycles after sampling; pending_any returns to 0.
- req=4'b1111 rising in the same cycle -> grants 0001, 0010, 0100, 1000, each 4 cycles apart; no drops.
- req[0] held high 20 cycles -> exactly one grant 0001.
- 9 presses on req[1] with meter_ready=0 -> count saturates at 7 and drop[1] pulses twice. Then meter_ready=1 -> exactly 7 grants 0010.
- Pending counts {ch0:2, ch3:1}, assert flush in the cycle after a grant -> in-flight grant completes, no further grants, pending_any=0.
- rst asserted during HOLDOFF with pending ch1=3 -> next cycle all outputs 0; after release the first press on req[0] and req[1] together grants channel 0 first.
